systolic_result_drain: RTL and testbench

SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

---
 rtl/systolic_result_drain.sv | 137 +++++++++++++
 tb/tb_systolic_result_drain.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures the nine accumulator results of a 3x3
// systolic array into a shadow buffer and streams them out one word per
// beat over a valid/ready handshake. A new frame arriving while one is
// still draining is dropped and flagged on the sticky overrun output.
// Optional macro DRAIN_CHECKSUM_EN appends a tenth beat carrying the XOR
// of the nine results, computed at capture.
module systolic_result_drain #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] res1,
  input  logic [W-1:0] res2,
  input  logic [W-1:0] res3,
  input  logic [W-1:0] res4,
  input  logic [W-1:0] res5,
  input  logic [W-1:0] res6,
  input  logic [W-1:0] res7,
  input  logic [W-1:0] res8,
  input  logic [W-1:0] res9,
  input  logic         res_valid,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         overrun,
  input  logic         clr_overrun
);

`ifdef DRAIN_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [3:0]          idx, idx_nxt;
  logic [8:0][W-1:0]   res_vec;
  logic [8:0][W-1:0]   shadow;
  logic [W-1:0]        beat;
  logic                xfer, last_xfer, capture, overrun_ev;

  // Element 0 is res1 (C[0][0]), element 8 is res9 (C[2][2]).
  assign res_vec = {res9, res8, res7, res6, res5, res4, res3, res2, res1};

  // State and beat index register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state: a capture on the last-beat transfer restarts at index 0
  // without passing through IDLE, so back-to-back frames have no bubble.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    capture    = 1'b0;
    overrun_ev = 1'b0;
    xfer       = (state == DRAIN) && out_ready;
    last_xfer  = xfer && (idx == LAST_IDX);
    case (state)
      IDLE: begin
        if (res_valid) begin
          capture   = 1'b1;
          state_nxt = DRAIN;
          idx_nxt   = 4'd0;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          idx_nxt = 4'd0;
          if (res_valid) capture   = 1'b1;
          else           state_nxt = IDLE;
        end else begin
          if (xfer)      idx_nxt    = idx + 4'd1;
          if (res_valid) overrun_ev = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 4'd0;
      end
    endcase
  end

  // Shadow buffer: written only on an accepted capture, so dropped frames
  // never disturb the frame being drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         shadow <= '0;
    else if (capture) shadow <= res_vec;
  end

  // Sticky overrun; a new drop in the same cycle beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             overrun <= 1'b0;
    else if (overrun_ev)  overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

`ifdef DRAIN_CHECKSUM_EN
  logic [W-1:0] csum, csum_nxt;

  // XOR of the nine incoming results, folded at capture time.
  always_comb begin
    csum_nxt = '0;
    for (int i = 0; i < 9; i++) csum_nxt ^= res_vec[i];
  end

  // Checksum register tracks the shadow buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         csum <= '0;
    else if (capture) csum <= csum_nxt;
  end

  assign beat = (idx == LAST_IDX) ? csum : shadow[idx];
`else
  assign beat = shadow[idx];
`endif

  // Outputs are pure functions of registered state, so they cannot change
  // while a beat is stalled and drop to zero the moment reset asserts.
  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_idx   = idx;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign out_data  = out_valid ? beat : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: directed scenarios plus random frames
// with random back-pressure, checked against a frame-level model of the
// expected beat sequence.
module tb_systolic_result_drain;
  localparam int W = 64;
`ifdef DRAIN_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] res [9];
  logic         res_valid = 1'b0;
  logic [W-1:0] out_data;
  logic [3:0]   out_idx;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic         overrun;
  logic         clr_overrun = 1'b0;

  int vec  = 0;
  int errs = 0;

  // Frame the DUT is expected to be draining.
  logic [W-1:0] exp_frame [9];

  always #5 clk = ~clk;

  systolic_result_drain #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .res1(res[0]), .res2(res[1]), .res3(res[2]), .res4(res[3]), .res5(res[4]),
    .res6(res[5]), .res7(res[6]), .res8(res[7]), .res9(res[8]),
    .res_valid(res_valid), .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Expected word for beat i of the modelled frame.
  function automatic logic [W-1:0] beat_of(input int i);
    logic [W-1:0] x;
    x = '0;
    if (i < 9) return exp_frame[i];
    for (int k = 0; k < 9; k++) x ^= exp_frame[k];
    return x;
  endfunction

  // Put a frame on the res inputs and make it the modelled frame.
  task automatic present(input logic [W-1:0] base, input int kind);
    for (int k = 0; k < 9; k++) begin
      case (kind)
        0:       res[k] = base + W'(k + 1);
        1:       res[k] = (k == 0) ? '1 : '0;
        default: res[k] = {$urandom, $urandom};
      endcase
      exp_frame[k] = res[k];
    end
  endtask

  // Drive out_ready and check beats [start, stop) of the modelled frame.
  // mode 0: always ready, 1: pattern 1,0,0 repeating, 2: random.
  task automatic drain(input int mode, input int start, input int stop,
                       output int cycles);
    int got = start;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [W-1:0] pd = '0;
    logic [3:0] pi = '0;
    logic rdy;
    while (got < stop && cyc < 300) begin
      @(negedge clk);
      cyc++;
      res_valid   = 1'b0;
      clr_overrun = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 1) % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (stalled) begin
        vec++;
        if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi) begin
          errs++;
          $display("FAIL stall_hold: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                   out_valid, out_idx, out_data, pi, pd);
        end
      end
      if (out_valid === 1'b1) begin
        vec++;
        if (out_idx !== 4'(got) || out_data !== beat_of(got) ||
            out_last !== (got == NB - 1)) begin
          errs++;
          $display("FAIL beat: idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                   out_idx, out_data, out_last, got, beat_of(got), (got == NB - 1));
        end
        stalled = !rdy;
        pd = out_data;
        pi = out_idx;
        if (rdy) got++;
      end else begin
        stalled = 1'b0;
      end
    end
    if (got < stop) begin
      errs++;
      $display("FAIL drain_timeout: got %0d beats, required %0d", got, stop);
    end
    cycles = cyc;
  endtask

  // After a drained frame the block must sit idle.
  task automatic expect_idle(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_idle: valid=%b busy=%b, required 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic expect_overrun(input string tag, input logic want);
    vec++;
    if (overrun !== want) begin
      errs++;
      $display("FAIL %s: overrun=%b, required %b", tag, overrun, want);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 9; k++) res[k] = '0;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    vec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
        out_idx !== 4'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errs++;
      $display("FAIL reset: valid=%b last=%b data=%h idx=%0d busy=%b ovr=%b, required all 0",
               out_valid, out_last, out_data, out_idx, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vec++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_ready_ignored: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    @(negedge clk);
    present('0, 0);
    res_valid = 1'b1;
    drain(0, 0, NB, cyc);
    vec++;
    if (cyc !== NB) begin
      errs++;
      $display("FAIL basic_latency: %0d cycles, required %0d", cyc, NB);
    end
    expect_idle("basic");
  endtask

  task automatic test_stall();
    int cyc;
    @(negedge clk);
    present('0, 0);
    res_valid = 1'b1;
    drain(1, 0, NB, cyc);
    expect_idle("stall");
  endtask

  task automatic test_overrun();
    int cyc;
    @(negedge clk);
    present('0, 0);
    res_valid = 1'b1;
    drain(0, 0, 3, cyc);
    @(negedge clk);
    out_ready = 1'b0;
    res_valid = 1'b1;
    for (int k = 0; k < 9; k++) res[k] = 64'hdead_0000 + W'(k);
    @(negedge clk);
    res_valid = 1'b0;
    expect_overrun("overrun_set", 1'b1);
    drain(0, 3, NB, cyc);
    expect_idle("overrun");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    expect_overrun("overrun_clear", 1'b0);
    // Clear coinciding with a fresh drop: the drop wins.
    present('0, 2);
    res_valid = 1'b1;
    drain(0, 0, 2, cyc);
    @(negedge clk);
    out_ready   = 1'b0;
    res_valid   = 1'b1;
    clr_overrun = 1'b1;
    @(negedge clk);
    res_valid   = 1'b0;
    clr_overrun = 1'b0;
    expect_overrun("overrun_clr_collide", 1'b1);
    drain(2, 2, NB, cyc);
    expect_idle("overrun2");
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    expect_overrun("overrun_clear2", 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    present('0, 0);
    res_valid = 1'b1;
    drain(0, 0, NB - 1, cyc);
    @(negedge clk);
    vec++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_idx !== 4'(NB - 1)) begin
      errs++;
      $display("FAIL b2b_last: valid=%b last=%b idx=%0d, required 1 1 %0d",
               out_valid, out_last, out_idx, NB - 1);
    end
    out_ready = 1'b1;
    present(64'd100, 0);
    res_valid = 1'b1;
    drain(0, 0, NB, cyc);
    vec++;
    if (cyc !== NB) begin
      errs++;
      $display("FAIL b2b_bubble: %0d cycles, required %0d", cyc, NB);
    end
    expect_overrun("b2b_no_overrun", 1'b0);
    expect_idle("b2b");
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    present('0, 2);
    res_valid = 1'b1;
    drain(0, 0, 5, cyc);
    @(negedge clk);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_idx !== 4'd0) begin
      errs++;
      $display("FAIL reset_mid: valid=%b busy=%b data=%h idx=%0d, required 0 0 0 0",
               out_valid, busy, out_data, out_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vec++;
      if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL reset_mid_quiet: cycle %0d valid=%b, required 0", c, out_valid);
      end
    end
  endtask

  task automatic test_boundary();
    int cyc;
    @(negedge clk);
    present('0, 1);
    res_valid = 1'b1;
    drain(0, 0, NB, cyc);
    expect_idle("boundary");
  endtask

  task automatic test_random();
    int cyc;
    for (int f = 0; f < 8; f++) begin
      @(negedge clk);
      present('0, 2);
      res_valid = 1'b1;
      drain(2, 0, NB, cyc);
      expect_idle("random");
    end
    expect_overrun("random_no_overrun", 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
